pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, PC and address width in bits.
REQ-002 Parameter STEP, default 2, sequential increment added to PC.
REQ-003 Parameter DEPTH, default 4, return-address stack entries (>=1).
REQ-004 Parameter RESET_ADDR, default 0, PC value on reset.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 stall  input  1  hold PC and stack; ignore all requests.
REQ-008 ret_en  input  1  pop return stack into PC.
REQ-009 call_en  input  1  push pc+STEP, load jump_addr.
REQ-010 jump_en  input  1  load jump_addr.
REQ-011 jump_addr  input  WIDTH  absolute target for call/jump.
REQ-012 branch_en  input  1  PC-relative branch.
REQ-013 branch_off  input  WIDTH  two's-complement offset added to current pc.
REQ-014 pc  output  WIDTH  registered current PC.
REQ-015 pc_next_seq  output  WIDTH  combinational pc+STEP.
REQ-016 stack_depth  output  clog2(DEPTH+1)  valid entries on return stack.
REQ-017 stack_overflow  output  1  sticky; call attempted with stack full.
REQ-018 stack_underflow  output  1  sticky; ret attempted with stack empty.

Function
REQ-019 Next-PC priority SHALL be: stall > ret_en > call_en > jump_en > branch_en > sequential (pc+STEP).
REQ-020 Selected value SHALL appear on pc at the first rising edge after the request is sampled (one-cycle latency); no request SHALL be pipelined or deferred.
REQ-021 All PC arithmetic SHALL be modulo 2^WIDTH; pc+STEP and pc+branch_off wrap silently without flags.
REQ-022 pc_next_seq SHALL equal pc+STEP (mod 2^WIDTH) combinationally in every cycle, including during stall.
REQ-023 Stall SHALL hold pc, stack contents, stack_depth and flags unchanged, regardless of other inputs.
REQ-024 Call with depth<DEPTH SHALL push pc+STEP, increment depth, load jump_addr.
REQ-025 Call with depth==DEPTH SHALL load jump_addr, discard the push, keep depth, set stack_overflow.
REQ-026 Ret with depth>0 SHALL load the top entry into pc and decrement depth (LIFO).
REQ-027 Ret with depth==0 SHALL advance pc to pc+STEP, keep depth 0, set stack_underflow.
REQ-028 Lower-priority requests asserted together with a winning request SHALL be dropped with no side effect (e.g. ret+call: pop only, no push).
REQ-029 stack_overflow and stack_underflow SHALL remain set until reset.

Reset
REQ-030 Reset assertion SHALL asynchronously force pc=RESET_ADDR, stack_depth=0, both flags 0; stack contents need not be cleared.
REQ-031 Reset asserted mid-call/ret SHALL abort the operation; first post-reset edge SHALL act as sequential from RESET_ADDR unless a request is present.
REQ-032 Reset deassertion SHALL be sampled synchronously; no request is honoured on an edge where reset is high.

Structure
REQ-033 Shared package pc_pkg SHALL hold the next-PC source encoding (SEQ, BRANCH, JUMP, CALL, RET, HOLD) and default parameter constants.
REQ-034 Return stack SHALL be a sub-module pc_ret_stack (push, pop, data in/out, depth, full, empty), parametrised by WIDTH and DEPTH.
REQ-035 Top level SHALL contain only the priority selector, adders, PC register and flag registers.

Verification (WIDTH=16, STEP=2, DEPTH=4, RESET_ADDR=0)
REQ-036 Release reset, no requests, 4 edges -> pc 0x0000,0x0002,0x0004,0x0006,0x0008; pc_next_seq always pc+2.
REQ-037 pc=0x0010, branch_en, branch_off=0xFFF8 -> pc=0x0008; pc=0xFFFE sequential -> pc=0x0000, no flag.
REQ-038 pc=0x0020, call_en, jump_addr=0x0100 -> pc=0x0100, depth=1; next edge ret_en -> pc=0x0022, depth=0.
REQ-039 Five consecutive calls -> depth=4, stack_overflow=1; four rets return the first four pushed addresses in reverse; fifth ret -> pc+2, stack_underflow=1.
REQ-040 stall=1 with jump_en=1, jump_addr=0x0200 -> pc, depth unchanged; ret_en+call_en with depth=1 -> pop only, depth=0.
REQ-041 Reset pulsed between edges during a call sequence -> pc=0x0000 and depth=0 before the next edge, flags cleared.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: next-PC source encoding,
// default parameter constants and the request priority function.
package pc_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_STEP       = 2;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_RESET_ADDR = 0;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4,
        HOLD   = 3'd5
    } next_src_e;

    // Fixed priority: stall > ret > call > jump > branch > sequential.
    function automatic next_src_e select_src(
        input logic stall,
        input logic ret_en,
        input logic call_en,
        input logic jump_en,
        input logic branch_en
    );
        next_src_e src;
        if (stall) begin
            src = HOLD;
        end else if (ret_en) begin
            src = RET;
        end else if (call_en) begin
            src = CALL;
        end else if (jump_en) begin
            src = JUMP;
        end else if (branch_en) begin
            src = BRANCH;
        end else begin
            src = SEQ;
        end
        return src;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack. Contents are not reset; only the depth
// counter is, so a reset empties the stack without touching storage.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [DW-1:0]    depth_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_d;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_pop  = pop_i & ~empty;
    // Pop wins if both arrive; the sequencer never asserts both together.
    assign do_push = push_i & ~pop_i & ~full;
    assign wr_idx  = AW'(depth_q);
    assign top_idx = AW'(depth_q - DW'(1));

    always_comb begin
        depth_d = depth_q;
        if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end else if (do_push) begin
            depth_d = depth_q + DW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign pop_data_o = empty ? '0 : mem_q[top_idx];
    assign depth_o    = depth_q;
    assign full_o     = full;
    assign empty_o    = empty;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection with
// PC-relative branch, absolute jump, call/return and sticky stack flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter int unsigned      STEP       = DEF_STEP,
    parameter int unsigned      DEPTH      = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR),
    localparam int unsigned     DW         = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             ret_en,
    input  logic             call_en,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_off,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic [DW-1:0]    stack_depth,
    output logic             stack_overflow,
    output logic             stack_underflow
);

    next_src_e        src;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] seq_addr;
    logic [WIDTH-1:0] branch_addr;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;

    assign src         = select_src(stall, ret_en, call_en, jump_en, branch_en);
    assign seq_addr    = pc_q + WIDTH'(STEP);
    assign branch_addr = pc_q + branch_off;

    // A call on a full stack still jumps; only the push is dropped.
    assign push = (src == CALL) & ~stk_full;
    assign pop  = (src == RET) & ~stk_empty;

    always_comb begin
        pc_d  = seq_addr;
        ovf_d = ovf_q;
        unf_d = unf_q;
        unique case (src)
            HOLD:   pc_d = pc_q;
            RET: begin
                if (stk_empty) begin
                    pc_d  = seq_addr;
                    unf_d = 1'b1;
                end else begin
                    pc_d = stk_top;
                end
            end
            CALL: begin
                pc_d = jump_addr;
                if (stk_full) begin
                    ovf_d = 1'b1;
                end
            end
            JUMP:   pc_d = jump_addr;
            BRANCH: pc_d = branch_addr;
            SEQ:    pc_d = seq_addr;
            default: pc_d = seq_addr;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_ADDR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (seq_addr),
        .pop_data_o  (stk_top),
        .depth_o     (stack_depth),
        .full_o      (stk_full),
        .empty_o     (stk_empty)
    );

    assign pc              = pc_q;
    assign pc_next_seq     = seq_addr;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
